muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_datapath.sv | 118 +++++++++++
 rtl/muldiv_sequencer.sv | 95 +++++++++
 tb/tb_muldiv_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer:
// funct3 op encodings, FSM states, iteration count and op-signedness helpers.
package muldiv_pkg;

   localparam int ITER  = 32;
   localparam int CNT_W = 5;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic op_is_div(input op_e op);
      return op[2];
   endfunction

   function automatic logic op_a_signed(input op_e op);
      return op inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic op_b_signed(input op_e op);
      return op inside {MUL, MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Arithmetic core: 64-bit accumulator/remainder register with shift-add
// (multiply) and restoring shift-subtract (divide) steps on operand magnitudes.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             fix_i,
   input  logic             early_out_i,
   input  op_e              op_i,
   input  logic [WIDTH-1:0] srca_i,
   input  logic [WIDTH-1:0] srcb_i,
   output logic             fast_o,
   output logic [WIDTH-1:0] result_o
);

   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   addend_q;
   logic [WIDTH-1:0]   src_a_q;
   logic [WIDTH-1:0]   result_q;
   op_e                op_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic               div_zero_q;
   logic               ovf_q;
   logic               mul_zero_q;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               div_zero, ovf, mul_zero;

   assign a_neg    = op_a_signed(op_i) & srca_i[WIDTH-1];
   assign b_neg    = op_b_signed(op_i) & srcb_i[WIDTH-1];
   assign a_mag    = a_neg ? -srca_i : srca_i;
   assign b_mag    = b_neg ? -srcb_i : srcb_i;
   assign div_zero = op_is_div(op_i) && (srcb_i == '0);
   assign ovf      = (op_i == DIV || op_i == REM) && (srca_i == MIN_NEG) && (srcb_i == ALL_ONES);
   assign mul_zero = !op_is_div(op_i) && (srca_i == '0 || srcb_i == '0);
   assign fast_o   = div_zero | ovf | (early_out_i & mul_zero);

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] step_val;

   // Multiply: hi += addend when lo[0], then shift {carry,hi,lo} right.
   // Divide: shift left, keep the trial subtraction only if it stays non-negative.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
      div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, addend_q};
      step_val = {mul_sum, acc_q[WIDTH-1:1]};
      if (op_is_div(op_q)) begin
         if (!div_diff[WIDTH]) step_val = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else                  step_val = {acc_q[2*WIDTH-2:0], 1'b0};
      end
   end

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem, fix_val;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      fix_val = '0;
      prod    = neg_res_q ? -acc_q : acc_q;
      quot    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      case (op_q)
         MUL:                 fix_val = prod[WIDTH-1:0];
         MULH, MULHSU, MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
         DIV, DIVU:           fix_val = div_zero_q ? ALL_ONES : (ovf_q ? MIN_NEG : quot);
         REM, REMU:           fix_val = div_zero_q ? src_a_q : (ovf_q ? '0 : rem);
         default:             fix_val = '0;
      endcase
      if (mul_zero_q) fix_val = '0;
   end

   // NOTE: sequential state uses non-blocking assignments, and every register
   // here is reset because a mid-operation reset must clear result and state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q      <= '0;
         addend_q   <= '0;
         src_a_q    <= '0;
         result_q   <= '0;
         op_q       <= MUL;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         mul_zero_q <= 1'b0;
      end else begin
         if (load_i) begin
            op_q       <= op_i;
            src_a_q    <= srca_i;
            acc_q      <= {{WIDTH{1'b0}}, (op_is_div(op_i) ? a_mag : b_mag)};
            addend_q   <= op_is_div(op_i) ? b_mag : a_mag;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= div_zero;
            ovf_q      <= ovf;
            mul_zero_q <= mul_zero;
         end else if (step_i) begin
            acc_q <= step_val;
         end
         if (fix_i) result_q <= fix_val;
      end
   end

   assign result_o = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer (IDLE/CALC/FIX/DONE) with pipeline stall.
// Optional MULDIV_EARLY_OUT_EN: MUL* with a zero operand takes the 2-cycle fast path.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   output logic             busy,
   output logic             stall_e,
   output logic             done,
   output logic [WIDTH-1:0] result
);

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic EARLY_OUT = 1'b1;
`else
   localparam logic EARLY_OUT = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load, step, fix, fast;

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (load),
      .step_i      (step),
      .fix_i       (fix),
      .early_out_i (EARLY_OUT),
      .op_i        (op_e'(op)),
      .srca_i      (srca),
      .srcb_i      (srcb),
      .fast_o      (fast),
      .result_o    (result)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = CNT_W'(ITER - 1);
               state_d = fast ? FIX : CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (cnt_q == '0) state_d = FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         FIX: begin
            fix     = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Flush wins over everything, including a start in the same cycle.
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         load    = 1'b0;
         step    = 1'b0;
         fix     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE) && !flush;
   assign stall_e = ((state_q == IDLE) && start && reset_n) || (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: latency/result model with per-cycle
// output comparison, directed corner vectors, flush and reset scenarios, random traffic.
module tb_muldiv_sequencer;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int ZERO_MUL_LAT = 2;
`else
   localparam int ZERO_MUL_LAT = 34;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] srca = '0;
   logic [31:0] srcb = '0;
   logic        busy, stall_e, done;
   logic [31:0] result;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .srca    (srca),
      .srcb    (srcb),
      .flush   (flush),
      .busy    (busy),
      .stall_e (stall_e),
      .done    (done),
      .result  (result)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   // Reference arithmetic straight from the RV32M definitions.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub, p;
      logic [63:0] up;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (f)
         OP_MUL:    begin p = sa * sb; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin up = ua * ub; return up[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         OP_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return 2;
      if ((f == OP_DIV || f == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      if (!f[2] && (a == 0 || b == 0)) return ZERO_MUL_LAT;
      return 34;
   endfunction

   // Model: an accepted op is "in flight" for t = 1..L cycles; done on t == L.
   bit          m_in = 1'b0;
   int          m_t = 0;
   int          m_lat = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_result = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_in = 1'b0; m_t = 0; m_lat = 0; m_result = '0;
      end else if (flush) begin
         m_in = 1'b0;
      end else if (!m_in) begin
         if (start) begin
            m_in = 1'b1; m_t = 1;
            m_lat  = ref_latency(op, srca, srcb);
            m_pend = ref_result(op, srca, srcb);
         end
      end else if (m_t == m_lat) begin
         m_in = 1'b0;
      end else begin
         m_t++;
         if (m_t == m_lat) m_result = m_pend;
      end
   end

   always @(negedge clk) begin
      check("busy",    32'(busy),    32'(m_in));
      check("done",    32'(done),    32'(m_in && m_t == m_lat && !flush));
      check("stall_e", 32'(stall_e), 32'(m_in ? (m_t < m_lat) : (start && reset_n)));
      check("result",  result,      m_result);
   end

   // Called just after a rising edge; returns just after the edge that ends DONE.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      start = 1'b1; op = f; srca = a; srcb = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); srca = $urandom; srcb = $urandom;
      lat = -1; res = '0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done) begin lat = n; res = result; break; end
         @(posedge clk); #1;
      end
      if (lat != -1) begin @(posedge clk); #1; end
   endtask

   task automatic do_vec(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      logic [31:0] r;
      int          l;
      check({name, " model"}, ref_result(f, a, b), exp_res);
      run_op(f, a, b, r, l);
      check({name, " result"}, r, exp_res);
      check({name, " latency"}, 32'(l), 32'(exp_lat));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1;
         4:       return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want summary");
      $fatal(1);
   end

   initial begin
      #12;
      check("reset busy",    32'(busy),    32'h0);
      check("reset done",    32'(done),    32'h0);
      check("reset stall_e", 32'(stall_e), 32'h0);
      check("reset result",  result,      32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      do_vec("mul_7_x_m3",    OP_MUL,    32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      do_vec("mulhu_max",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      do_vec("mulh_m1_m1",    OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         34);
      do_vec("mulhsu_m1_2",   OP_MULHSU, 32'hFFFF_FFFF,  32'h2,         32'hFFFF_FFFF, 34);
      do_vec("div_ovf",       OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
      do_vec("rem_ovf",       OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2);
      do_vec("divu_5_by_0",   OP_DIVU,   32'h5,          32'h0,         32'hFFFF_FFFF, 2);
      do_vec("remu_5_by_0",   OP_REMU,   32'h5,          32'h0,         32'h5,         2);
      do_vec("rem_m7_2",      OP_REM,    32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFF, 34);
      do_vec("div_m7_2",      OP_DIV,    32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFD, 34);

      // Flush a DIVU in its cycle 10, then restart in the very next cycle.
      start = 1'b1; op = OP_DIVU; srca = 32'd100; srcb = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy",   32'(busy), 32'h0);
      check("flush done",   32'(done), 32'h0);
      check("flush result", result,    32'hFFFF_FFFD);
      do_vec("divu_after_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);

      // Asynchronous reset in cycle 20 of a MUL, away from any clock edge.
      start = 1'b1; op = OP_MUL; srca = 32'd3; srcb = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midop reset busy",    32'(busy),    32'h0);
      check("midop reset done",    32'(done),    32'h0);
      check("midop reset stall_e", 32'(stall_e), 32'h0);
      check("midop reset result",  result,      32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_vec("mul_0_x_9", OP_MUL, 32'h0, 32'h9, 32'h0, ZERO_MUL_LAT);

      // Random traffic: starts while busy, occasional flushes, corner operands.
      for (int c = 0; c < 4000; c++) begin
         start = ($urandom % 2) == 0;
         op    = 3'($urandom);
         srca  = pick();
         srcb  = pick();
         flush = ($urandom % 64) == 0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      flush = 1'b0;
      repeat (40) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
